// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 definitions: register numbers, command encodings, field positions.
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
package cp0_pkg;

  // CP0 register numbers (ins[15:11])
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;
  localparam logic [4:0] CP0_PRID   = 5'd15;

  // Decoder coprocessor command; MFC0 is a pure read and arrives as COP_NONE
  typedef enum logic [1:0] {
    COP_NONE    = 2'b00,
    COP_MTC0    = 2'b01,
    COP_SYSCALL = 2'b10,
    COP_ERET    = 2'b11
  } cop_cmd_e;

  // Exception codes written into Cause.ExcCode
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;

  // Status field positions
  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int STATUS_IM_LO   = 10;

  // Cause field positions
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 10;

  // Software-writable Status bits: IM[15:10], EXL, IE
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FC03;

  // Sequencer state; the encoding is the Status.EXL bit itself
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HANDLER = 1'b1
  } cp0_state_e;

  // The single action chosen this cycle after priority resolution
  typedef enum logic [2:0] {
    ACT_NONE = 3'd0,
    ACT_INT  = 3'd1,
    ACT_SYS  = 3'd2,
    ACT_ERET = 3'd3,
    ACT_MTC0 = 3'd4
  } cp0_act_e;

  // Assemble the architectural Cause word from its stored fields
  function automatic logic [31:0] pack_cause(input logic [5:0] ip, input logic [4:0] exc);
    logic [31:0] w;
    w = '0;
    w[CAUSE_IP_LO +: 6]  = ip;
    w[CAUSE_EXC_LO +: 5] = exc;
    return w;
  endfunction

endpackage

// File: rtl/cp0_exc_unit.sv
// CP0 register bank (Status/Cause/EPC/PRId) and exception/ERET sequencer.
// Latency: redirect/squash/rdata combinational; register updates land at the next clk edge.
// Backpressure: none; instr_valid=0 marks a bubble and suppresses every action.
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_3000,
  parameter logic [31:0] PRID_VALUE = 32'h0000_0018,
  parameter int          NUM_IRQ    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         cop_cmd,
  input  logic               instr_valid,
  input  logic [31:0]        pc,
  input  logic [4:0]         cp0_addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               redirect,
  output logic [31:0]        redirect_addr,
  output logic               squash,
  output logic               exl
);

  // Architectural state; EXL lives in state_q
  cp0_state_e         state_q;
  cp0_state_e         state_d;
  logic               ie_q;
  logic [NUM_IRQ-1:0] im_q;
  logic [NUM_IRQ-1:0] ip_q;
  logic [4:0]         exc_q;
  logic [31:0]        epc_q;

  // Decode helpers
  cop_cmd_e    cmd;
  logic        int_req;
  cp0_act_e    act;
  logic [31:0] wdata_status;
  logic [31:0] status_rd;
  logic [5:0]  ip_field;

  assign cmd          = cop_cmd_e'(cop_cmd);
  assign wdata_status = wdata & STATUS_WMASK;

  // An enabled, unmasked pending interrupt is only taken on a real instruction outside the handler
  assign int_req = ie_q & (state_q == ST_RUN) & (|(ip_q & im_q)) & instr_valid;

  // Priority resolution: interrupt > SYSCALL > ERET > MTC0; reset suppresses everything
  always_comb begin
    act = ACT_NONE;
    if (!rst && instr_valid) begin
      if (int_req) begin
        act = ACT_INT;
      end else begin
        unique case (cmd)
          COP_SYSCALL: act = ACT_SYS;
          COP_ERET:    act = ACT_ERET;
          COP_MTC0:    act = ACT_MTC0;
          default:     act = ACT_NONE;
        endcase
      end
    end
  end

  // Sequencer state register (EXL)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequencer next state: exceptions enter the handler, ERET or a Status write with EXL=0 leave it
  always_comb begin
    state_d = state_q;
    unique case (act)
      ACT_INT, ACT_SYS: state_d = ST_HANDLER;
      ACT_ERET:         state_d = ST_RUN;
      ACT_MTC0: begin
        if (cp0_addr == CP0_STATUS) begin
          state_d = cp0_state_e'(wdata_status[STATUS_EXL_BIT]);
        end
      end
      default:          state_d = state_q;
    endcase
  end

  // Sequencer outputs: NPC redirect target and commit squash
  always_comb begin
    redirect      = 1'b0;
    redirect_addr = EXC_VECTOR;
    squash        = 1'b0;
    unique case (act)
      ACT_INT: begin
        redirect = 1'b1;
        squash   = 1'b1;
      end
      ACT_SYS: begin
        redirect = 1'b1;
      end
      ACT_ERET: begin
        redirect      = 1'b1;
        redirect_addr = epc_q;
      end
      default: begin
        redirect = 1'b0;
      end
    endcase
  end

  assign exl = (state_q == ST_HANDLER);

  // Register bank updates: IP sampling every cycle, exception capture and masked MTC0 writes
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q  <= 1'b0;
      im_q  <= '0;
      ip_q  <= '0;
      exc_q <= EXC_INT;
      epc_q <= '0;
    end else begin
      ip_q <= irq;
      unique case (act)
        ACT_INT: begin
          epc_q <= pc;
          exc_q <= EXC_INT;
        end
        ACT_SYS: begin
          exc_q <= EXC_SYS;
          // A nested SYSCALL must not overwrite the return address of the outer one
          if (state_q == ST_RUN) begin
            epc_q <= pc;
          end
        end
        ACT_MTC0: begin
          if (cp0_addr == CP0_STATUS) begin
            ie_q <= wdata_status[STATUS_IE_BIT];
            im_q <= wdata_status[STATUS_IM_LO +: NUM_IRQ];
          end else if (cp0_addr == CP0_EPC) begin
            epc_q <= wdata;
          end
        end
        default: begin
          exc_q <= exc_q;
        end
      endcase
    end
  end

  // Zero-extend the interrupt fields into their architectural 6-bit slots
  always_comb begin
    status_rd = '0;
    status_rd[STATUS_IE_BIT]           = ie_q;
    status_rd[STATUS_EXL_BIT]          = exl;
    status_rd[STATUS_IM_LO +: NUM_IRQ] = im_q;
    ip_field = '0;
    ip_field[NUM_IRQ-1:0] = ip_q;
  end

  // MFC0 read port: reflects state before the current edge
  always_comb begin
    rdata = '0;
    unique case (cp0_addr)
      CP0_STATUS: rdata = status_rd;
      CP0_CAUSE:  rdata = pack_cause(ip_field, exc_q);
      CP0_EPC:    rdata = epc_q;
      CP0_PRID:   rdata = PRID_VALUE;
      default:    rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed self-checking bench for cp0_exc_unit: vector table plus multi-cycle sequences.
// Inputs change 1ns after posedge, outputs are sampled on negedge.
// No flow control on this block; every vector takes exactly one cycle.
module tb_cp0_exc_unit;

  localparam logic [31:0] EV = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cop_cmd;
  logic        instr_valid;
  logic [31:0] pc;
  logic [4:0]  cp0_addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [5:0]  irq;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        squash;
  logic        exl;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cp0_exc_unit dut (
    .clk(clk), .rst(rst), .cop_cmd(cop_cmd), .instr_valid(instr_valid), .pc(pc),
    .cp0_addr(cp0_addr), .wdata(wdata), .rdata(rdata), .irq(irq), .redirect(redirect),
    .redirect_addr(redirect_addr), .squash(squash), .exl(exl)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  cmd;
    logic        v;
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [5:0]  irq;
    logic [31:0] e_rdata;
    logic        e_red;
    logic [31:0] e_raddr;
    logic        e_sq;
    logic        e_exl;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  function automatic vec_t mk(logic r, logic [1:0] c, logic v, logic [31:0] p, logic [4:0] a,
                              logic [31:0] w, logic [5:0] i, logic [31:0] er, logic ered,
                              logic [31:0] era, logic esq, logic eexl);
    vec_t t;
    t.rst = r; t.cmd = c; t.v = v; t.pc = p; t.addr = a; t.wdata = w; t.irq = i;
    t.e_rdata = er; t.e_red = ered; t.e_raddr = era; t.e_sq = esq; t.e_exl = eexl;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after posedge and wait to the sampling point
  task automatic step(input logic r, input logic [1:0] c, input logic v, input logic [31:0] p,
                      input logic [4:0] a, input logic [31:0] w, input logic [5:0] i);
    @(posedge clk);
    #1;
    rst = r; cop_cmd = c; instr_valid = v; pc = p; cp0_addr = a; wdata = w; irq = i;
    @(negedge clk);
  endtask

  initial begin
    // cmd: 0 none, 1 MTC0, 2 SYSCALL, 3 ERET
    // Reset state and PRId
    tbl[0]  = mk(1, 0, 0, 32'h0,    12, 32'h0,          6'h00, 32'h0,     0, EV,           0, 0);
    tbl[1]  = mk(0, 0, 1, 32'h0,    12, 32'h0,          6'h00, 32'h0,     0, EV,           0, 0);
    tbl[2]  = mk(0, 0, 1, 32'h0,    13, 32'h0,          6'h00, 32'h0,     0, EV,           0, 0);
    tbl[3]  = mk(0, 0, 1, 32'h0,    14, 32'h0,          6'h00, 32'h0,     0, EV,           0, 0);
    tbl[4]  = mk(0, 0, 1, 32'h0,    15, 32'h0,          6'h00, 32'h18,    0, EV,           0, 0);
    // Status write mask; write sets EXL as a side effect
    tbl[5]  = mk(0, 1, 1, 32'h0,    12, 32'hFFFF_FFFF,  6'h00, 32'h0,     0, EV,           0, 0);
    tbl[6]  = mk(0, 0, 1, 32'h0,    12, 32'h0,          6'h00, 32'hFC03,  0, EV,           0, 1);
    tbl[7]  = mk(0, 0, 1, 32'h0,    7,  32'h0,          6'h00, 32'h0,     0, EV,           0, 1);
    tbl[8]  = mk(0, 1, 1, 32'h0,    12, 32'h0,          6'h00, 32'hFC03,  0, EV,           0, 1);
    tbl[9]  = mk(0, 0, 1, 32'h0,    12, 32'h0,          6'h00, 32'h0,     0, EV,           0, 0);
    // SYSCALL and nested SYSCALL
    tbl[10] = mk(0, 2, 1, 32'h100,  14, 32'h0,          6'h00, 32'h0,     1, EV,           0, 0);
    tbl[11] = mk(0, 0, 1, 32'h104,  14, 32'h0,          6'h00, 32'h100,   0, EV,           0, 1);
    tbl[12] = mk(0, 0, 1, 32'h104,  13, 32'h0,          6'h00, 32'h20,    0, EV,           0, 1);
    tbl[13] = mk(0, 2, 1, 32'h3004, 14, 32'h0,          6'h00, 32'h100,   1, EV,           0, 1);
    tbl[14] = mk(0, 0, 1, 32'h3008, 14, 32'h0,          6'h00, 32'h100,   0, EV,           0, 1);
    // ERET from handler, then ERET with EXL already 0
    tbl[15] = mk(0, 1, 1, 32'h300C, 14, 32'h104,        6'h00, 32'h100,   0, EV,           0, 1);
    tbl[16] = mk(0, 3, 1, 32'h3010, 14, 32'h0,          6'h00, 32'h104,   1, 32'h104,      0, 1);
    tbl[17] = mk(0, 0, 1, 32'h104,  12, 32'h0,          6'h00, 32'h0,     0, EV,           0, 0);
    tbl[18] = mk(0, 3, 1, 32'h108,  14, 32'h0,          6'h00, 32'h104,   1, 32'h104,      0, 0);
    tbl[19] = mk(0, 0, 1, 32'h104,  12, 32'h0,          6'h00, 32'h0,     0, EV,           0, 0);
    // Interrupt: enable IM[10]/IE, bubble does not take it, then MTC0 dropped
    tbl[20] = mk(0, 1, 1, 32'h1F0,  12, 32'h401,        6'h01, 32'h0,     0, EV,           0, 0);
    tbl[21] = mk(0, 0, 0, 32'h1F4,  13, 32'h0,          6'h01, 32'h420,   0, EV,           0, 0);
    tbl[22] = mk(0, 1, 1, 32'h200,  14, 32'hDEAD_BEEF,  6'h01, 32'h104,   1, EV,           1, 0);
    tbl[23] = mk(0, 0, 1, 32'h3000, 14, 32'h0,          6'h00, 32'h200,   0, EV,           0, 1);
    tbl[24] = mk(0, 0, 1, 32'h3004, 13, 32'h0,          6'h00, 32'h0,     0, EV,           0, 1);
    tbl[25] = mk(0, 0, 1, 32'h3008, 12, 32'h0,          6'h00, 32'h403,   0, EV,           0, 1);
    // Reset wins over ERET inside the handler
    tbl[26] = mk(1, 3, 1, 32'h300C, 12, 32'h0,          6'h00, 32'h403,   0, EV,           0, 1);
    tbl[27] = mk(0, 0, 1, 32'h0,    12, 32'h0,          6'h00, 32'h0,     0, EV,           0, 0);
    tbl[28] = mk(0, 0, 1, 32'h0,    14, 32'h0,          6'h00, 32'h0,     0, EV,           0, 0);

    rst = 1'b1; cop_cmd = 2'b00; instr_valid = 1'b0; pc = '0; cp0_addr = '0; wdata = '0; irq = '0;
    @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].rst, tbl[i].cmd, tbl[i].v, tbl[i].pc, tbl[i].addr, tbl[i].wdata, tbl[i].irq);
      check($sformatf("v%0d rdata", i),         rdata,                 tbl[i].e_rdata);
      check($sformatf("v%0d redirect", i),      {31'b0, redirect},     {31'b0, tbl[i].e_red});
      check($sformatf("v%0d redirect_addr", i), redirect_addr,         tbl[i].e_raddr);
      check($sformatf("v%0d squash", i),        {31'b0, squash},       {31'b0, tbl[i].e_sq});
      check($sformatf("v%0d exl", i),           {31'b0, exl},          {31'b0, tbl[i].e_exl});
    end

    // irq-to-IP latency, interrupt beats a concurrent SYSCALL
    step(0, 2'd1, 1, 32'h4F0, 5'd12, 32'h401, 6'h00);
    check("h1 redirect", {31'b0, redirect}, 32'd0);
    step(0, 2'd0, 1, 32'h4F4, 5'd13, 32'h0, 6'h01);
    check("h2 redirect_latency", {31'b0, redirect}, 32'd0);
    check("h2 cause", rdata, 32'h0);
    step(0, 2'd2, 1, 32'h500, 5'd13, 32'h0, 6'h01);
    check("h3 redirect", {31'b0, redirect}, 32'd1);
    check("h3 squash_int_over_sys", {31'b0, squash}, 32'd1);
    check("h3 redirect_addr", redirect_addr, EV);
    check("h3 cause_ip", rdata, 32'h400);
    step(0, 2'd0, 1, 32'h3000, 5'd13, 32'h0, 6'h01);
    check("h4 cause_exc_int", rdata, 32'h400);
    check("h4 exl", {31'b0, exl}, 32'd1);
    check("h4 masked_in_handler", {31'b0, redirect}, 32'd0);
    step(0, 2'd0, 1, 32'h3004, 5'd14, 32'h0, 6'h01);
    check("h5 epc", rdata, 32'h500);
    // Leave the handler by clearing EXL through MTC0 with the line still high
    step(0, 2'd1, 1, 32'h3008, 5'd12, 32'h401, 6'h01);
    check("h6 redirect", {31'b0, redirect}, 32'd0);
    check("h6 exl", {31'b0, exl}, 32'd1);
    step(0, 2'd0, 1, 32'h600, 5'd12, 32'h0, 6'h01);
    check("h7 status", rdata, 32'h401);
    check("h7 exl", {31'b0, exl}, 32'd0);
    check("h7 redirect_reint", {31'b0, redirect}, 32'd1);
    check("h7 squash", {31'b0, squash}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
